// File: rtl/row_sweep_pkg.sv
// Shared types and defaults for the word-line row sweep controller.
package row_sweep_pkg;

  localparam int DEFAULT_ADDR_W = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] base;
    logic [DEFAULT_ADDR_W:0]   count;
    logic [DEFAULT_ADDR_W-1:0] stride;
  } cmd_t;

endpackage

// File: rtl/row_sweep_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves away from the winner on update.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt_valid,
  output logic gnt_idx
);

  logic prefer1;

  always_ff @(posedge clk) begin
    if (rst)
      prefer1 <= 1'b0;
    else if (update)
      prefer1 <= ~gnt_idx;
  end

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = (req0 & req1) ? prefer1 : req1;
  end

endmodule

// File: rtl/row_sweep_ctrl.sv
// Arbitrates two sweep requesters and steps the granted sweep through the row decoder.
//
// state   | meaning
// S_IDLE  | waiting for a command; arbiter grant drives req*_ready
// S_SWEEP | presenting one row per step_ready; remaining counts down to 1
// S_DONE  | one-cycle completion pulse, then back to idle
module row_sweep_ctrl
  import row_sweep_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_base,
  input  logic [CNT_W-1:0]  req0_count,
  input  logic [ADDR_W-1:0] req0_stride,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_base,
  input  logic [CNT_W-1:0]  req1_count,
  input  logic [ADDR_W-1:0] req1_stride,
  input  logic              abort,
  input  logic              step_ready,
  output logic              dec_en,
  output logic [ADDR_W-1:0] dec_addr,
  output logic              busy,
  output logic              owner,
  output logic              done,
  output logic              aborted
);

  state_t            state;
  logic [ADDR_W-1:0] stride;
  logic [CNT_W-1:0]  remaining;

  logic              gnt_valid;
  logic              gnt_idx;
  logic              idle;
  logic              hs;
  logic [ADDR_W-1:0] sel_base;
  logic [ADDR_W-1:0] sel_stride;
  logic [CNT_W-1:0]  sel_count;

  assign idle = (state == S_IDLE);
  assign hs   = idle & gnt_valid;

  assign req0_ready = hs & ~gnt_idx;
  assign req1_ready = hs &  gnt_idx;

  assign sel_base   = gnt_idx ? req1_base   : req0_base;
  assign sel_stride = gnt_idx ? req1_stride : req0_stride;
  assign sel_count  = gnt_idx ? req1_count  : req0_count;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0_valid),
    .req1      (req1_valid),
    .update    (hs),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dec_addr  <= '0;
      stride    <= '0;
      remaining <= '0;
      dec_en    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs) begin
            dec_addr  <= sel_base;
            stride    <= sel_stride;
            remaining <= sel_count;
            owner     <= gnt_idx;
            busy      <= 1'b1;
            aborted   <= 1'b0;
            if (sel_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state  <= S_SWEEP;
              dec_en <= 1'b1;
            end
          end
        end
        S_SWEEP: begin
          if (abort) begin
            state   <= S_DONE;
            dec_en  <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (step_ready) begin
            remaining <= remaining - CNT_W'(1);
            // The final accept leaves dec_addr on the last presented row.
            if (remaining == CNT_W'(1)) begin
              state  <= S_DONE;
              dec_en <= 1'b0;
              done   <= 1'b1;
            end else begin
              dec_addr <= dec_addr + stride;
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          aborted <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          dec_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_sweep_ctrl.sv
// Directed bench for row_sweep_ctrl with hand-computed expectations.
module tb_row_sweep_ctrl;
  import row_sweep_pkg::*;

  localparam int AW = DEFAULT_ADDR_W;
  localparam int CW = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_base, req1_base, req0_stride, req1_stride;
  logic [CW-1:0] req0_count, req1_count;
  logic          abort, step_ready;
  logic          dec_en, busy, owner, done, aborted;
  logic [AW-1:0] dec_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  row_sweep_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_base   (req0_base),
    .req0_count  (req0_count),
    .req0_stride (req0_stride),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_base   (req1_base),
    .req1_count  (req1_count),
    .req1_stride (req1_stride),
    .abort       (abort),
    .step_ready  (step_ready),
    .dec_en      (dec_en),
    .dec_addr    (dec_addr),
    .busy        (busy),
    .owner       (owner),
    .done        (done),
    .aborted     (aborted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int idx, input cmd_t c);
    if (idx == 0) begin
      req0_valid = 1'b1; req0_base = c.base; req0_count = c.count; req0_stride = c.stride;
    end else begin
      req1_valid = 1'b1; req1_base = c.base; req1_count = c.count; req1_stride = c.stride;
    end
    #1;
  endtask

  task automatic chk_row(input string tag, input logic [31:0] addr, input logic [31:0] own);
    chk({tag, ".dec_en"}, 32'(dec_en), 1);
    chk({tag, ".dec_addr"}, 32'(dec_addr), addr);
    chk({tag, ".owner"}, 32'(owner), own);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  task automatic chk_done(input string tag, input logic [31:0] addr, input logic [31:0] own,
                          input logic [31:0] ab);
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".aborted"}, 32'(aborted), ab);
    chk({tag, ".dec_en"}, 32'(dec_en), 0);
    chk({tag, ".dec_addr"}, 32'(dec_addr), addr);
    chk({tag, ".owner"}, 32'(owner), own);
    chk({tag, ".busy"}, 32'(busy), 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".dec_en"}, 32'(dec_en), 0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_base = '0; req0_count = '0; req0_stride = '0;
    req1_base = '0; req1_count = '0; req1_stride = '0;
    abort = 1'b0; step_ready = 1'b0;
    step();
    step();

    chk("rst.dec_en", 32'(dec_en), 0);
    chk("rst.dec_addr", 32'(dec_addr), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.owner", 32'(owner), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.aborted", 32'(aborted), 0);
    chk("rst.req0_ready", 32'(req0_ready), 0);
    chk("rst.req1_ready", 32'(req1_ready), 0);
    rst = 1'b0;

    // single sweep: 5, 7, 9
    step_ready = 1'b1;
    post(0, '{base: 10'd5, count: 11'd3, stride: 10'd2});
    chk("single.req0_ready", 32'(req0_ready), 1);
    chk("single.req1_ready", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    chk_row("single.r0", 5, 0);
    chk("single.busy", 32'(busy), 1);
    chk("single.ready_in_sweep", 32'(req0_ready), 0);
    step(); chk_row("single.r1", 7, 0);
    step(); chk_row("single.r2", 9, 0);
    step(); chk_done("single.done", 9, 0, 0);
    step(); chk_idle("single.idle");

    // address wrap: 1020, 0, 4
    post(0, '{base: 10'd1020, count: 11'd3, stride: 10'd4});
    step();
    req0_valid = 1'b0;
    chk_row("wrap.r0", 1020, 0);
    step(); chk_row("wrap.r1", 0, 0);
    step(); chk_row("wrap.r2", 4, 0);
    step(); chk_done("wrap.done", 4, 0, 0);
    step(); chk_idle("wrap.idle");

    // back-pressure: base held while step_ready is low
    step_ready = 1'b0;
    post(0, '{base: 10'd100, count: 11'd2, stride: 10'd1});
    step();
    req0_valid = 1'b0;
    chk_row("bp.hold0", 100, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_row($sformatf("bp.hold%0d", i + 1), 100, 0);
    end
    step_ready = 1'b1;
    step(); chk_row("bp.r1", 101, 0);
    step(); chk_done("bp.done", 101, 0, 0);
    step(); chk_idle("bp.idle");

    // arbitration from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    post(0, '{base: 10'd10, count: 11'd1, stride: 10'd0});
    post(1, '{base: 10'd20, count: 11'd1, stride: 10'd0});
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("arb%0d.req0_ready", g), 32'(req0_ready), (g % 2 == 0) ? 1 : 0);
      chk($sformatf("arb%0d.req1_ready", g), 32'(req1_ready), (g % 2 == 1) ? 1 : 0);
      step();
      chk_row($sformatf("arb%0d.row", g), (g % 2 == 0) ? 10 : 20, g % 2);
      chk($sformatf("arb%0d.no_ready", g), 32'(req0_ready | req1_ready), 0);
      step();
      chk_done($sformatf("arb%0d.done", g), (g % 2 == 0) ? 10 : 20, g % 2, 0);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk_idle("arb.idle");

    // abort on 4th presented row
    post(0, '{base: 10'd0, count: 11'd10, stride: 10'd3});
    step();
    req0_valid = 1'b0;
    chk_row("abort.r0", 0, 0);
    step(); chk_row("abort.r1", 3, 0);
    step(); chk_row("abort.r2", 6, 0);
    step(); chk_row("abort.r3", 9, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_done("abort.done", 9, 0, 1);
    step();
    chk_idle("abort.idle");
    chk("abort.aborted_clear", 32'(aborted), 0);

    // abort in idle is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_idle");

    // zero count: done next cycle, dec_en never set
    post(1, '{base: 10'd50, count: 11'd0, stride: 10'd1});
    chk("zero.req1_ready", 32'(req1_ready), 1);
    step();
    req1_valid = 1'b0;
    chk_done("zero.done", 50, 1, 0);
    step(); chk_idle("zero.idle");

    // reset during row 2 of 6
    post(0, '{base: 10'd200, count: 11'd6, stride: 10'd1});
    step();
    req0_valid = 1'b0;
    chk_row("rstmid.r0", 200, 0);
    step(); chk_row("rstmid.r1", 201, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid.dec_en", 32'(dec_en), 0);
    chk("rstmid.dec_addr", 32'(dec_addr), 0);
    chk("rstmid.owner", 32'(owner), 0);
    chk("rstmid.done", 32'(done), 0);
    chk("rstmid.busy", 32'(busy), 0);
    step();
    chk_idle("rstmid.after");
    post(1, '{base: 10'd300, count: 11'd2, stride: 10'd5});
    chk("rstmid.req1_ready", 32'(req1_ready), 1);
    step();
    req1_valid = 1'b0;
    chk_row("rstmid.new0", 300, 1);
    step(); chk_row("rstmid.new1", 305, 1);
    step(); chk_done("rstmid.done_new", 305, 1, 0);
    step(); chk_idle("rstmid.idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
